// File: rtl/shift_arbiter64.sv
// Round-robin arbiter sharing one 64-bit barrel shifter among NUM_REQ requesters.
// Define SHIFT_ARB_PIPE_EN to insert a registered operand stage ahead of the shifter.
module shift_arbiter64 #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_in,
  input  logic [NUM_REQ*6-1:0]  req_shift_amount,
  input  logic [NUM_REQ*2-1:0]  req_shift_type,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_result,
  output logic [ID_W-1:0]       rsp_id
);

  logic [63:0]     op_in   [NUM_REQ];
  logic [5:0]      op_amt  [NUM_REQ];
  logic [1:0]      op_type [NUM_REQ];

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] next_ptr;
  logic            grant_found;
  logic            issue_can_accept;
  logic            accept;
  logic            rsp_accept;

  logic            load_valid;
  logic [63:0]     load_result;
  logic [ID_W-1:0] load_id;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_in[i]   = req_in[64*i +: 64];
    assign op_amt[i]  = req_shift_amount[6*i +: 6];
    assign op_type[i] = req_shift_type[2*i +: 2];
  end

  // Left shifts (logical or arithmetic) zero-fill; only 2'b11 sign-extends.
  function automatic logic [63:0] shift64(input logic [63:0] v, input logic [5:0] amt,
                                          input logic [1:0] kind);
    logic [63:0] r;
    case (kind)
      2'b01:   r = v >> amt;
      2'b11:   r = $unsigned($signed(v) >>> amt);
      default: r = v << amt;
    endcase
    return r;
  endfunction

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign rsp_accept = !rsp_valid || rsp_ready;
  assign accept     = grant_found && issue_can_accept;
  assign next_ptr   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= next_ptr;
    end
  end

`ifdef SHIFT_ARB_PIPE_EN
  logic            stage_valid;
  logic [63:0]     stage_in;
  logic [5:0]      stage_amt;
  logic [1:0]      stage_type;
  logic [ID_W-1:0] stage_id;

  // The operand stage empties into the response register whenever that register accepts.
  assign issue_can_accept = !stage_valid || rsp_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_in    <= '0;
      stage_amt   <= '0;
      stage_type  <= '0;
      stage_id    <= '0;
    end else if (issue_can_accept) begin
      stage_valid <= accept;
      if (accept) begin
        stage_in   <= op_in[grant_idx];
        stage_amt  <= op_amt[grant_idx];
        stage_type <= op_type[grant_idx];
        stage_id   <= grant_idx;
      end
    end
  end

  assign load_valid  = stage_valid;
  assign load_result = shift64(stage_in, stage_amt, stage_type);
  assign load_id     = stage_id;
`else
  assign issue_can_accept = rsp_accept;
  assign load_valid       = accept;
  assign load_result      = shift64(op_in[grant_idx], op_amt[grant_idx], op_type[grant_idx]);
  assign load_id          = grant_idx;
`endif

  // A draining response is replaced in the same edge, sustaining one op per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else if (rsp_accept) begin
      rsp_valid <= load_valid;
      if (load_valid) begin
        rsp_result <= load_result;
        rsp_id     <= load_id;
      end
    end
  end

endmodule

// File: doc/shift_arbiter64.md
# shift_arbiter64

Round-robin scheduler that shares one 64-bit barrel shifter datapath (logical/arithmetic, left/right) among NUM_REQ independent requesters. Each requester issues operations over a valid/ready channel. Winning operations are issued to the shifter, and results return on a single shared response channel with backpressure, tagged with the requester index. It sits between the ALU issue logic and the shifter core, so the team instantiates one shifter per cluster instead of one per lane.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ): width of the response tag; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_in  in  NUM_REQ*64  operand; requester i occupies bits [64*i+63:64*i].
- req_shift_amount  in  NUM_REQ*6  shift amount 0..63; requester i occupies [6*i+5:6*i].
- req_shift_type  in  NUM_REQ*2  per requester: 00 logical left, 01 logical right, 10 arithmetic left, 11 arithmetic right.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_result  out  64  shifted result.
- rsp_id  out  ID_W  index of the requester that issued this result.

## Operation
- Arbitration: round-robin pointer rr_ptr (ID_W bits).
  - The grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The grant is computed combinationally.
- Issue stage can accept when it is empty, or when its held entry advances this cycle.
  - Final (response) stage: accept = !rsp_valid || rsp_ready.
- req_ready[g] = grant[g] & issue_can_accept. All other req_ready bits are 0.
- req_ready does not depend on req_valid of any non-granted requester.
- Acceptance is req_valid[g] & req_ready[g].
  - On acceptance, rr_ptr <= (g+1) mod NUM_REQ.
  - Without acceptance, rr_ptr holds.
- Shifter semantics:
  - Logical left and arithmetic left are identical: zero fill on the right.
  - Logical right zero-fills.
  - Arithmetic right replicates in[63].
  - Shift amount 0 returns the operand unchanged.
- Response register loads {result, id} when it accepts.
  - rsp_valid is set on load.
  - rsp_valid is cleared when rsp_ready=1 and nothing new loads.
- Response contents are stable while rsp_valid=1 and rsp_ready=0.
- Responses return in acceptance order. There is no reordering and no drop.
- Simultaneous drain and load (rsp_valid=1, rsp_ready=1, new acceptance): the new result replaces the old in the same edge. Sustained throughput is 1 op/cycle.
- Reset values:
  - rsp_valid=0, rsp_result=0, rsp_id=0.
  - rr_ptr=0.
  - Pipeline stage valid=0.
- Reset mid-operation discards all in-flight operations. No response is produced for them.
- A requester that deasserts req_valid before acceptance loses nothing. No state is held for it.

## Timing
- Base latency: acceptance at edge t produces rsp_valid=1 with that result after edge t, i.e. visible in cycle t+1.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, all req_ready=0 and rr_ptr holds.
  - The held response persists indefinitely.
- First cycle after rst deasserts: req_ready may assert (pipeline empty).
- Fairness: a requester holding req_valid=1 is accepted within NUM_REQ acceptances.
- No combinational path from rsp_ready to any req_ready except through issue_can_accept.
  - The path is one AND level when the pipeline is full.

## Configuration
- Macro SHIFT_ARB_PIPE_EN.
- Defined:
  - An operand stage is inserted between arbitration and the shifter. It registers the operand, shift amount, shift type, id and a valid bit.
  - The shifter evaluates from this stage into the response register.
  - Latency is 2 cycles: accept at edge t, rsp_valid visible in cycle t+2.
  - The operand stage advances when the response stage accepts.
  - Issue accepts when the operand stage is empty or advancing.
  - Throughput remains 1 op/cycle. Backpressure propagates with one stage of buffering.
  - Operand stage valid resets to 0.
- Undefined: single-stage behaviour described above, latency 1.

## Test plan
- Single op: requester 2 sends in=0x8000_0000_0000_0001, amount=4, type=11, rsp_ready=1 -> rsp_result=0xF800_0000_0000_0000, rsp_id=2, one cycle later (two with SHIFT_ARB_PIPE_EN).
- All-type sweep: in=0xF0F0_0000_0000_000F, amount=8, types 00/01/10/11 -> 0xF000_0000_0000_0F00, 0x00F0_F000_0000_0000, 0xF000_0000_0000_0F00, 0xFFF0_F000_0000_0000. Amount=0 -> operand unchanged.
- Round-robin: NUM_REQ=4, all req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,… on consecutive cycles; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles with 3 requesters valid -> exactly one (or two, pipelined) ops accepted. rsp_result/rsp_id stable. No req_ready after pipeline full. On rsp_ready=1, results drain in order with no loss.
- Reset mid-flight: accept op, assert rst for 1 cycle before the response drains -> rsp_valid=0, rr_ptr=0, no stale response after release.
- Random stress: 10k ops, random valid/rsp_ready -> every accepted op returns exactly once, in order, matching the reference model. Per-requester wait ≤ NUM_REQ acceptances.
